// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipeline applying a bitwise gate op to A/B, with zero flag and transfer counter
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] tx_count
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d, res;
  logic             z_q, z_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic             s1_load, s2_load, out_xfer;
  always_comb begin
    res = a_q;
    case (op_q)
      3'b000: res = a_q & b_q;
      3'b001: res = ~(a_q & b_q);
      3'b010: res = a_q | b_q;
      3'b011: res = ~(a_q | b_q);
      3'b100: res = a_q ^ b_q;
      3'b101: res = ~(a_q ^ b_q);
      3'b110: res = ~a_q;
      default: res = a_q;
    endcase
  end
  // S1 may refill in the same cycle it drains into S2
  always_comb begin
    s2_load     = s1_valid_q && (!out_valid_q || out_ready);
    in_ready    = !s1_valid_q || s2_load;
    s1_load     = in_valid && in_ready;
    out_xfer    = out_valid_q && out_ready;
    s1_valid_d  = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    a_d         = s1_load ? A : a_q;
    b_d         = s1_load ? B : b_q;
    op_d        = s1_load ? OP : op_q;
    out_valid_d = s2_load ? 1'b1 : (out_xfer ? 1'b0 : out_valid_q);
    y_d         = s2_load ? res : y_q;
    z_d         = s2_load ? (res == '0) : z_q;
    tx_count_d  = tx_count_q + CNT_W'(out_xfer);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      z_q         <= 1'b0;
      tx_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      z_q         <= z_d;
      tx_count_q  <= tx_count_d;
    end
  end
  assign Y         = y_q;
  assign Z         = z_q;
  assign out_valid = out_valid_q;
  assign tx_count  = tx_count_q;
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed-vector bench for logic_gate_pipe; a second instance with CNT_W=2 covers counter wrap
module tb_logic_gate_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [2:0] OP = '0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, Z, out_valid;
  logic [7:0] Y;
  logic [15:0] tx_count;
  logic       ir2, z2, ov2;
  logic [7:0] y2;
  logic [1:0] tx2;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tt [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
  logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .OP(OP), .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .Z(Z), .out_valid(out_valid), .out_ready(out_ready), .tx_count(tx_count));

  logic_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .OP(OP), .in_valid(in_valid), .in_ready(ir2),
    .Y(y2), .Z(z2), .out_valid(ov2), .out_ready(out_ready), .tx_count(tx2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; OP = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; A = 8'hF0; B = 8'h00; OP = 3'd7; out_ready = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ir: got %b want 1", in_ready); end
    vectors++; if (tx_count !== 16'd0) begin miscompares++; $display("FAIL reset_tx: got %0d want 0", tx_count); end
    vectors++; if (Y !== 8'h00 || Z !== 1'b0) begin miscompares++; $display("FAIL reset_yz: got Y=%h Z=%b want Y=00 Z=0", Y, Z); end
    @(negedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hold_ov: got %b want 0", out_valid); end
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_ir: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if (out_valid !== 1'b1 || Y !== 8'hF0) begin miscompares++; $display("FAIL first_edge_accept: got ov=%b Y=%h want ov=1 Y=F0", out_valid, Y); end
    out_ready = 1'b0;
  endtask

  task automatic test_truth_table;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8); A = 8'hF0; B = 8'hCC; OP = 3'(c); out_ready = 1'b1;
      #1;
      if (c >= 2) begin
        vectors++;
        if (out_valid !== 1'b1 || Y !== tt[c-2]) begin miscompares++; $display("FAIL truth_op%0d: got ov=%b Y=%h want ov=1 Y=%h", c-2, out_valid, Y, tt[c-2]); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_zero_flag;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 2); A = 8'h00; B = 8'hFF; OP = (c == 0) ? 3'd0 : 3'd2; out_ready = 1'b1;
      #1;
      if (c == 2) begin
        vectors++; if (Y !== 8'h00 || Z !== 1'b1) begin miscompares++; $display("FAIL zero_and: got Y=%h Z=%b want Y=00 Z=1", Y, Z); end
      end
      if (c == 3) begin
        vectors++; if (Y !== 8'hFF || Z !== 1'b0) begin miscompares++; $display("FAIL zero_or: got Y=%h Z=%b want Y=FF Z=0", Y, Z); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    do_reset();
    for (int c = 0; c < 30 && got < 4; c++) begin
      out_ready = (c >= 5); in_valid = (sent < 4); A = 8'(sent + 1); B = 8'h00; OP = 3'd7;
      #1;
      if (c >= 2 && c <= 4) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
        vectors++; if (out_valid !== 1'b1 || Y !== 8'h01) begin miscompares++; $display("FAIL bp_hold_c%0d: got ov=%b Y=%h want ov=1 Y=01", c, out_valid, Y); end
      end
      if (out_valid && out_ready) begin
        vectors++; if (Y !== 8'(got + 1)) begin miscompares++; $display("FAIL bp_order_%0d: got Y=%h want %h", got, Y, 8'(got + 1)); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    vectors++; if (got != 4) begin miscompares++; $display("FAIL bp_timeout: got %0d results want 4", got); end
    #1;
    vectors++; if (tx_count !== 16'd4) begin miscompares++; $display("FAIL bp_tx_count: got %0d want 4", tx_count); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 16); A = 8'(c); B = 8'h0F; OP = 3'd4; out_ready = 1'b1;
      #1;
      if (c < 16) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ir_c%0d: got %b want 1", c, in_ready); end
      end
      if (c >= 2) begin
        vectors++;
        if (out_valid !== 1'b1 || Y !== (8'(c - 2) ^ 8'h0F)) begin miscompares++; $display("FAIL b2b_res_%0d: got ov=%b Y=%h want ov=1 Y=%h", c-2, out_valid, Y, 8'(c - 2) ^ 8'h0F); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    vectors++; if (tx_count !== 16'd16) begin miscompares++; $display("FAIL b2b_tx_count: got %0d want 16", tx_count); end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 5); A = 8'(c); B = 8'h00; OP = 3'd7; out_ready = 1'b1;
      #1;
      if (c >= 3) begin
        vectors++; if (tx2 !== wrap_exp[c-3]) begin miscompares++; $display("FAIL wrap_%0d: got tx=%0d want %0d", c-3, tx2, wrap_exp[c-3]); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; A = 8'(8'hA0 + c); B = 8'h00; OP = 3'd7; out_ready = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || tx_count !== 16'd1) begin miscompares++; $display("FAIL mid_full: got ov=%b ir=%b tx=%0d want ov=1 ir=0 tx=1", out_valid, in_ready, tx_count); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ov: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ir: got %b want 1", in_ready); end
    vectors++; if (tx_count !== 16'd0) begin miscompares++; $display("FAIL mid_rst_tx: got %0d want 0", tx_count); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale_c%0d: got ov=%b want 0", c, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_zero_flag();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result bit width (legal range 1..64).
REQ-002 Parameter: CNT_W, default 16, width of the completed-transaction counter (legal range 1..32).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 Port: A  input  WIDTH  operand A.
REQ-006 Port: B  input  WIDTH  operand B.
REQ-007 Port: OP  input  3  operation select, captured together with A and B.
REQ-008 Port: in_valid  input  1  A/B/OP hold a valid request.
REQ-009 Port: in_ready  output  1  block accepts a request this cycle.
REQ-010 Port: Y  output  WIDTH  registered result.
REQ-011 Port: Z  output  1  registered flag: Y is all zeros.
REQ-012 Port: out_valid  output  1  Y and Z hold a valid result.
REQ-013 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-014 Port: tx_count  output  CNT_W  number of results consumed, modulo 2^CNT_W.

Function
REQ-015 OP encoding, bitwise per lane: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A (B ignored), 111 pass A (B ignored).
REQ-016 Every OP value is legal; there is no error path.
REQ-017 Handshakes: an input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-018 Pipeline: two registered stages. S1 holds A/B/OP plus s1_valid. S2 holds Y/Z plus out_valid.
REQ-019 S2 loads when s1_valid and (!out_valid or out_ready).
REQ-020 S1 loads when in_valid and in_ready.
REQ-021 in_ready = !s1_valid or S2 loads this cycle (combinational; no dependency on in_valid).
REQ-022 Latency: a request accepted at edge N produces out_valid high after edge N+1 when no backpressure is applied.
REQ-023 Throughput: one transfer per cycle sustained while out_ready stays high.
REQ-024 Backpressure: while out_valid is high and out_ready is low, Y and Z hold stable and S1 retains its contents.
REQ-025 Under backpressure, in_ready drops only once S1 is also occupied, so at most two results are in flight.
REQ-026 Ordering: no request is dropped, duplicated or reordered.
REQ-027 Simultaneous output transfer and S1-to-S2 advance in the same cycle: out_valid stays high and Y takes the new value.
REQ-028 Simultaneous input accept and S1 advance in the same cycle: S1 takes the new request.
REQ-029 Z = 1 exactly when the registered Y equals 0; Z updates in the same cycle as Y.
REQ-030 tx_count increments by 1 on each output transfer.
REQ-031 tx_count wraps from 2^CNT_W-1 to 0 with no saturation flag.
REQ-032 Y and Z are don't-care while out_valid is low, but shall not change unless S2 loads.

Reset
REQ-033 rst_n low asynchronously clears s1_valid, out_valid, Y, Z and tx_count to 0, including mid-transaction.
REQ-034 In-flight requests are discarded on reset.
REQ-035 in_ready reads 1 during and immediately after reset.
REQ-036 Reset release is synchronised externally.
REQ-037 The first edge after release may accept a request.

Verification
REQ-038 Truth table: WIDTH=8, A=0xF0, B=0xCC, OP sweeping 0..7 with out_ready=1 -> Y = C0, 3F, FC, 03, 3C, C3, 0F, F0, each appearing 2 cycles after accept.
REQ-039 Zero flag: A=0x00, B=0xFF, OP=AND -> Y=0x00 and Z=1; then OP=OR -> Y=0xFF and Z=0.
REQ-040 Backpressure: stream 4 requests with out_ready low for 3 cycles -> in_ready low after 2 accepts, Y stable, then all 4 results delivered in order with tx_count=4.
REQ-041 Back-to-back: 16 consecutive requests with out_ready=1 -> 16 results on 16 consecutive cycles, with in_ready constantly 1.
REQ-042 Wrap: CNT_W=2, 5 output transfers -> tx_count reads 1,2,3,0,1.
REQ-043 Reset mid-operation: assert rst_n low with both stages full -> out_valid=0, tx_count=0 and in_ready=1 immediately (no clock edge needed), and no stale result appears after release.
